low_power_detector: RTL and testbench

Upstream stage of the low-power PIO input. Consumes the battery-voltage ADC sample stream and averages it over fixed windows. Applies threshold hysteresis with multi-window confirmation and drives a single debounced low_power level. That level wires directly to the PIO in_port, where software sees the level and its rising edge.

---
 rtl/low_power_pkg.sv | 28 ++
 rtl/window_averager.sv | 79 +++++++
 rtl/low_power_detector.sv | 81 ++++++++
 tb/tb_low_power_detector.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/low_power_pkg.sv
// Shared types and default constants for the low-power battery detector.
// Build option: define LOW_POWER_FORCE_EN to add the force_low override input.
package low_power_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    EVAL  = 1'b1
  } window_state_t;

  typedef enum logic {
    NORMAL = 1'b0,
    LOW    = 1'b1
  } level_state_t;

  localparam int          DEF_SAMPLE_W    = 12;
  localparam int          DEF_AVG_LOG2    = 4;
  localparam logic [11:0] DEF_LOW_THRESH  = 12'h600;
  localparam logic [11:0] DEF_HIGH_THRESH = 12'h6C0;
  localparam int          DEF_CONFIRM_CNT = 4;

  // Window sum of 2^avg_log2 full-scale samples fits exactly in this many bits.
  function automatic int acc_width(input int sample_w, input int avg_log2);
    return sample_w + avg_log2;
  endfunction

  localparam int DEF_ACC_W = acc_width(DEF_SAMPLE_W, DEF_AVG_LOG2);

endpackage

// File: rtl/window_averager.sv
// Sums fixed windows of 2^AVG_LOG2 ADC samples and publishes the truncated mean.
// Handshake: a sample moves when sample_valid && sample_ready; upstream holds data until then.
module window_averager
  import low_power_pkg::*;
#(
  parameter int SAMPLE_W = DEF_SAMPLE_W,
  parameter int AVG_LOG2 = DEF_AVG_LOG2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample_data,
  output logic                sample_ready,
  output logic [SAMPLE_W-1:0] avg_out,
  output logic                avg_valid,
  output logic [SAMPLE_W-1:0] avg_next,
  output window_state_t       win_state_o
);

  localparam int ACC_W = acc_width(SAMPLE_W, AVG_LOG2);

  window_state_t       state_q, state_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [AVG_LOG2-1:0] cnt_q, cnt_d;
  logic [SAMPLE_W-1:0] avg_q, avg_d;
  logic                avg_valid_q, avg_valid_d;
  logic                xfer;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      avg_q       <= '0;
      avg_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      avg_q       <= avg_d;
      avg_valid_q <= avg_valid_d;
    end
  end

  // Shift-by-AVG_LOG2 is a plain bit select: truncating mean of the window.
  assign avg_next = acc_q[ACC_W-1:AVG_LOG2];

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    avg_d        = avg_q;
    avg_valid_d  = 1'b0;
    sample_ready = !reset && (state_q == ACCUM);
    xfer         = sample_valid && sample_ready;
    case (state_q)
      ACCUM: begin
        if (xfer) begin
          acc_d = acc_q + ACC_W'(sample_data);
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == '1) state_d = EVAL;
        end
      end
      EVAL: begin
        avg_d       = avg_next;
        avg_valid_d = 1'b1;
        acc_d       = '0;
        cnt_d       = '0;
        state_d     = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  assign avg_out     = avg_q;
  assign avg_valid   = avg_valid_q;
  assign win_state_o = state_q;

endmodule

// File: rtl/low_power_detector.sv
// Windowed battery average with hysteresis and multi-window confirmation driving low_power.
// Build option: LOW_POWER_FORCE_EN adds force_low, OR'ed onto the registered level.
module low_power_detector
  import low_power_pkg::*;
#(
  parameter int                  SAMPLE_W    = DEF_SAMPLE_W,
  parameter int                  AVG_LOG2    = DEF_AVG_LOG2,
  parameter logic [SAMPLE_W-1:0] LOW_THRESH  = DEF_LOW_THRESH,
  parameter logic [SAMPLE_W-1:0] HIGH_THRESH = DEF_HIGH_THRESH,
  parameter int                  CONFIRM_CNT = DEF_CONFIRM_CNT
) (
  input  logic                clk,
  input  logic                reset,
`ifdef LOW_POWER_FORCE_EN
  input  logic                force_low,
`endif
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample_data,
  output logic                sample_ready,
  output logic                low_power,
  output logic [SAMPLE_W-1:0] avg_out,
  output logic                avg_valid
);

  localparam int CONF_W = $clog2(CONFIRM_CNT + 1);

  logic [SAMPLE_W-1:0] avg_next;
  window_state_t       win_state;
  level_state_t        level_q, level_d;
  logic [CONF_W-1:0]   conf_q, conf_d;
  logic                qualify;

  window_averager #(
    .SAMPLE_W (SAMPLE_W),
    .AVG_LOG2 (AVG_LOG2)
  ) u_avg (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .sample_ready (sample_ready),
    .avg_out      (avg_out),
    .avg_valid    (avg_valid),
    .avg_next     (avg_next),
    .win_state_o  (win_state)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      level_q <= NORMAL;
      conf_q  <= '0;
    end else begin
      level_q <= level_d;
      conf_q  <= conf_d;
    end
  end

  // Level moves only on the EVAL cycle, judged on the average being published.
  always_comb begin
    level_d = level_q;
    conf_d  = conf_q;
    qualify = (level_q == NORMAL) ? (avg_next < LOW_THRESH) : (avg_next >= HIGH_THRESH);
    if (win_state == EVAL) begin
      if (!qualify) begin
        conf_d = '0;
      end else if (conf_q == CONF_W'(CONFIRM_CNT - 1)) begin
        conf_d  = '0;
        level_d = (level_q == NORMAL) ? LOW : NORMAL;
      end else begin
        conf_d = conf_q + 1'b1;
      end
    end
  end

`ifdef LOW_POWER_FORCE_EN
  assign low_power = (level_q == LOW) || force_low;
`else
  assign low_power = (level_q == LOW);
`endif

endmodule

// File: tb/tb_low_power_detector.sv
// Directed bench for low_power_detector: window averaging, hysteresis, confirmation, reset.
module tb_low_power_detector;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sample_valid = 1'b0;
  logic [11:0] sample_data = 12'h000;
  logic        sample_ready;
  logic        low_power;
  logic [11:0] avg_out;
  logic        avg_valid;
`ifdef LOW_POWER_FORCE_EN
  logic        force_low = 1'b0;
`endif

  int total = 0;
  int bad = 0;
  int n_valid = 0;

  typedef struct {
    logic        eval_ready;
    logic        eval_valid;
    logic        done_valid;
    logic        done_ready;
    logic [11:0] avg;
    logic        lp;
  } obs_t;

  low_power_detector dut (
    .clk          (clk),
    .reset        (reset),
`ifdef LOW_POWER_FORCE_EN
    .force_low    (force_low),
`endif
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .sample_ready (sample_ready),
    .low_power    (low_power),
    .avg_out      (avg_out),
    .avg_valid    (avg_valid)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (avg_valid === 1'b1) n_valid++;

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Offer one sample and hold it until it transfers; returns just after the transfer edge.
  task automatic send(input logic [11:0] d);
    bit done = 1'b0;
    sample_valid = 1'b1;
    sample_data  = d;
    for (int w = 0; w < 20 && !done; w++) begin
      @(negedge clk);
      if (sample_ready === 1'b1) done = 1'b1;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL send_timeout: sample_ready never rose, required 1");
    end
    @(posedge clk); #1;
    sample_valid = 1'b0;
  endtask

  // Send n samples, then observe the EVAL cycle and the result cycle.
  task automatic drive_window(input logic [11:0] d, input int n, output obs_t o);
    for (int i = 0; i < n; i++) send(d);
    @(negedge clk);
    o.eval_ready = sample_ready;
    o.eval_valid = avg_valid;
    @(negedge clk);
    o.done_valid = avg_valid;
    o.done_ready = sample_ready;
    o.avg        = avg_out;
    o.lp         = low_power;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (sample_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b expected 0", sample_ready); end
    total++; if (low_power !== 1'b0) begin bad++; $display("FAIL rst_low_power: got %b expected 0", low_power); end
    total++; if (avg_out !== 12'h000) begin bad++; $display("FAIL rst_avg_out: got %h expected 000", avg_out); end
    total++; if (avg_valid !== 1'b0) begin bad++; $display("FAIL rst_avg_valid: got %b expected 0", avg_valid); end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    total++; if (sample_ready !== 1'b1) begin bad++; $display("FAIL ready_after_rst: got %b expected 1", sample_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_first_window();
    obs_t o;
    int nv = n_valid;
    drive_window(12'h800, 16, o);
    total++; if (o.eval_ready !== 1'b0) begin bad++; $display("FAIL w1_eval_ready: got %b expected 0", o.eval_ready); end
    total++; if (o.eval_valid !== 1'b0) begin bad++; $display("FAIL w1_eval_valid: got %b expected 0", o.eval_valid); end
    total++; if (o.done_ready !== 1'b1) begin bad++; $display("FAIL w1_ready_back: got %b expected 1", o.done_ready); end
    total++; if (o.done_valid !== 1'b1) begin bad++; $display("FAIL w1_avg_valid: got %b expected 1", o.done_valid); end
    total++; if (o.avg !== 12'h800) begin bad++; $display("FAIL w1_avg: got %h expected 800", o.avg); end
    total++; if (o.lp !== 1'b0) begin bad++; $display("FAIL w1_low_power: got %b expected 0", o.lp); end
    @(negedge clk);
    total++; if (avg_valid !== 1'b0) begin bad++; $display("FAIL w1_pulse_len: got %b expected 0", avg_valid); end
    @(posedge clk); #1;
    total++; if (n_valid - nv !== 1) begin bad++; $display("FAIL w1_pulse_count: got %0d expected 1", n_valid - nv); end
  endtask

  task automatic test_enter_low();
    obs_t o;
    for (int i = 0; i < 4; i++) begin
      drive_window(12'h500, 16, o);
      total++; if (o.avg !== 12'h500 || o.done_valid !== 1'b1) begin bad++; $display("FAIL enter_avg[%0d]: got %h/%b expected 500/1", i, o.avg, o.done_valid); end
      total++; if (o.lp !== (i == 3)) begin bad++; $display("FAIL enter_lp[%0d]: got %b expected %b", i, o.lp, i == 3); end
    end
  endtask

  task automatic test_hysteresis();
    obs_t o;
    for (int i = 0; i < 4; i++) begin
      drive_window(12'h650, 16, o);
      total++; if (o.lp !== 1'b1) begin bad++; $display("FAIL hyst_mid_lp[%0d]: got %b expected 1", i, o.lp); end
    end
    for (int i = 0; i < 4; i++) begin
      drive_window(12'h6C0, 16, o);
      total++; if (o.avg !== 12'h6C0) begin bad++; $display("FAIL hyst_avg[%0d]: got %h expected 6c0", i, o.avg); end
      total++; if (o.lp !== (i != 3)) begin bad++; $display("FAIL hyst_exit_lp[%0d]: got %b expected %b", i, o.lp, i != 3); end
    end
  endtask

  task automatic test_count_restart();
    obs_t o;
    logic [11:0] d;
    for (int i = 0; i < 7; i++) begin
      d = (i == 3) ? 12'h700 : 12'h500;
      drive_window(d, 16, o);
      total++; if (o.lp !== 1'b0) begin bad++; $display("FAIL restart_lp[%0d]: got %b expected 0", i, o.lp); end
    end
    drive_window(12'h500, 16, o);
    total++; if (o.lp !== 1'b1) begin bad++; $display("FAIL restart_fourth_lp: got %b expected 1", o.lp); end
  endtask

  task automatic test_reset_mid_window();
    obs_t o;
    int nv;
    for (int i = 0; i < 7; i++) send(12'h100);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++; if (low_power !== 1'b0) begin bad++; $display("FAIL mid_rst_lp: got %b expected 0", low_power); end
    total++; if (avg_out !== 12'h000) begin bad++; $display("FAIL mid_rst_avg: got %h expected 000", avg_out); end
    @(posedge clk); #1;
    reset = 1'b0;
    nv = n_valid;
    for (int i = 0; i < 15; i++) send(12'h900);
    repeat (3) @(posedge clk);
    #1;
    total++; if (n_valid !== nv) begin bad++; $display("FAIL mid_early_valid: got %0d pulses expected 0", n_valid - nv); end
    drive_window(12'h900, 1, o);
    total++; if (o.done_valid !== 1'b1) begin bad++; $display("FAIL mid_valid: got %b expected 1", o.done_valid); end
    total++; if (o.avg !== 12'h900) begin bad++; $display("FAIL mid_avg: got %h expected 900", o.avg); end
    total++; if (o.lp !== 1'b0) begin bad++; $display("FAIL mid_lp: got %b expected 0", o.lp); end
  endtask

  task automatic test_held_across_eval();
    obs_t o;
    for (int i = 0; i < 16; i++) send((i % 2 == 0) ? 12'h001 : 12'h002);
    sample_valid = 1'b1;
    sample_data  = 12'h0F0;
    @(negedge clk);
    total++; if (sample_ready !== 1'b0) begin bad++; $display("FAIL held_eval_ready: got %b expected 0", sample_ready); end
    @(negedge clk);
    total++; if (sample_ready !== 1'b1) begin bad++; $display("FAIL held_ready_back: got %b expected 1", sample_ready); end
    total++; if (avg_valid !== 1'b1 || avg_out !== 12'h001) begin bad++; $display("FAIL held_avg: got %h/%b expected 001/1", avg_out, avg_valid); end
    @(posedge clk); #1;
    sample_valid = 1'b0;
    drive_window(12'h010, 15, o);
    total++; if (o.done_valid !== 1'b1) begin bad++; $display("FAIL held_next_valid: got %b expected 1", o.done_valid); end
    total++; if (o.avg !== 12'h01E) begin bad++; $display("FAIL held_next_avg: got %h expected 01e", o.avg); end
    total++; if (o.lp !== 1'b0) begin bad++; $display("FAIL held_lp: got %b expected 0", o.lp); end
  endtask

  initial begin
    test_reset();
    test_first_window();
    test_enter_low();
    test_hysteresis();
    test_count_restart();
    test_reset_mid_window();
    test_held_across_eval();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
